// File: rtl/la_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_core
// Purpose  : Logic-analyser capture engine with masked level/edge trigger,
//            programmable pre-trigger depth and oldest-first readout.
// Revision : 1.0
// ============================================================================
module la_capture_core #(
    parameter int DATA_W = 14,
    parameter int TRIG_W = 4,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pre_trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [TRIG_W-1:0] trig_edge_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_req_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic [1:0]        state_o,
    output logic              busy_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_pos_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]  r_data_d;
    logic [TRIG_W-1:0]  r_trig_d;
    logic [TRIG_W-1:0]  r_trig_q;
    logic               r_hist_valid;
    logic [ADDR_W-1:0]  r_pre;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ADDR_W-1:0]  r_count;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_trig_pos;
    logic [ADDR_W:0]    r_rd_cnt;
    logic               r_triggered;
    logic               r_done;
    logic               r_rd_valid;
    logic               r_rd_last;
    logic [DATA_W-1:0]  r_rd_data;

    logic               w_capturing;
    logic [TRIG_W-1:0]  w_bit_ok;
    logic               w_fire;
    logic [ADDR_W-1:0]  w_count_inc;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_count_inc = r_count + ADDR_W'(1);

    // Unmasked bits always pass; edge bits also need the previous sample to differ.
    assign w_bit_ok = ~trig_mask_i
                    | (~(r_trig_d ^ trig_value_i)
                       & (~trig_edge_i | ((r_trig_q ^ trig_value_i) & {TRIG_W{r_hist_valid}})));
    assign w_fire   = &w_bit_ok;

    always_ff @(posedge clk_i) begin
        if (w_capturing) begin
            r_mem[r_wr_addr] <= r_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_data_d     <= '0;
            r_trig_d     <= '0;
            r_trig_q     <= '0;
            r_hist_valid <= 1'b0;
            r_pre        <= '0;
            r_wr_addr    <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_trig_pos   <= '0;
            r_rd_cnt     <= '0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_data_d   <= data_i;
            r_trig_d   <= trig_i;
            r_trig_q   <= r_trig_d;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (abort_i) begin
                r_state <= S_IDLE;
                r_done  <= 1'b0;
            end else if (arm_i && (r_state == S_IDLE || r_state == S_DONE)) begin
                r_pre        <= pre_trig_i;
                r_wr_addr    <= '0;
                r_count      <= '0;
                r_triggered  <= 1'b0;
                r_done       <= 1'b0;
                r_hist_valid <= 1'b0;
                r_state      <= (pre_trig_i == '0) ? S_WAIT : S_PRE;
            end else begin
                if (w_capturing) begin
                    r_wr_addr    <= r_wr_addr + ADDR_W'(1);
                    r_hist_valid <= 1'b1;
                end
                case (r_state)
                    S_PRE: begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_pre) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_fire) begin
                            r_trig_pos  <= r_wr_addr;
                            r_triggered <= 1'b1;
                            r_count     <= '0;
                            if (r_pre == ADDR_W'(DEPTH - 1)) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_rd_ptr <= r_wr_addr - r_pre;
                                r_rd_cnt <= '0;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        r_count <= w_count_inc;
                        // ~r_pre equals DEPTH-1-P: the number of post-trigger samples.
                        if (w_count_inc == ~r_pre) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_rd_ptr <= r_trig_pos - r_pre;
                            r_rd_cnt <= '0;
                        end
                    end
                    S_DONE: begin
                        if (rd_req_i && !r_rd_cnt[ADDR_W]) begin
                            r_rd_data  <= r_mem[r_rd_ptr];
                            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                            r_rd_cnt   <= r_rd_cnt + (ADDR_W+1)'(1);
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= (r_rd_cnt == (ADDR_W+1)'(DEPTH - 1));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_o     = (r_state == S_DONE) ? 2'd0 : r_state[1:0];
    assign busy_o      = w_capturing;
    assign triggered_o = r_triggered;
    assign done_o      = r_done;
    assign trig_pos_o  = r_trig_pos;
    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign rd_last_o   = r_rd_last;

endmodule
`default_nettype wire

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised embedded logic-analyser capture engine for in-fabric debug of video and CMOS timing nets (vsync, href, de, line counters).
- Samples a DATA_W-bit probe bus every clock into a circular DEPTH-entry RAM.
- Evaluates a multi-bit masked level/edge trigger and keeps a programmable number of pre-trigger samples.
- After capture, the DEPTH samples are read back oldest-first through a sequential request/valid port, normally driven by the JTAG control bridge.

Parameters:
DATA_W, 14, probe bus width
TRIG_W, 4, trigger input width
DEPTH, 1024, capture depth in samples; power of two, >= 4
ADDR_W, $clog2(DEPTH), RAM address width (derived)

Ports:
clk_i  in  1  sample clock; only clock
rst_n  in  1  asynchronous active-low reset
arm_i  in  1  pulse: start capture; accepted in IDLE or DONE only
abort_i  in  1  pulse: return to IDLE from any state
pre_trig_i  in  ADDR_W  pre-trigger sample count; latched on accepted arm
trig_mask_i  in  TRIG_W  1 = bit participates in trigger
trig_value_i  in  TRIG_W  required value per bit
trig_edge_i  in  TRIG_W  per bit: 0 = level match, 1 = transition into value
trig_i  in  TRIG_W  trigger nets
data_i  in  DATA_W  probe nets
rd_req_i  in  1  request next readout sample; honoured in DONE only
rd_data_o  out  DATA_W  readout sample
rd_valid_o  out  1  rd_data_o valid, one-cycle pulse
rd_last_o  out  1  with rd_valid_o, marks the DEPTH-th sample
state_o  out  2  0 IDLE, 1 PRE, 2 WAIT, 3 POST; DONE is reported as 0 with done_o=1
busy_o  out  1  high in PRE, WAIT or POST
triggered_o  out  1  set when the trigger fires; cleared on arm
done_o  out  1  capture complete; cleared on arm or abort
trig_pos_o  out  ADDR_W  RAM address of the trigger sample

Behaviour:
- Reset: state IDLE. All outputs 0. wr_addr, count and rd_ptr are 0. RAM contents are don't-care.
- Input stage: data_i and trig_i are registered once (data_d, trig_d). A second register holds trig_q, the previous trig_d, for edge detection. All trigger logic and RAM writes use the registered values.
- Accepted arm, in IDLE or DONE:
  - Latch pre_trig_i as P; wr_addr<=0, count<=0.
  - Clear triggered_o and done_o.
  - Mark the edge history invalid.
  - Next state is PRE, or WAIT if P==0.
- arm_i in PRE, WAIT or POST is ignored. abort_i has priority over arm_i in the same cycle.
- Write rule: in PRE, WAIT and POST, write data_d to RAM[wr_addr] every cycle, then wr_addr++ (wraps mod DEPTH). Every sample is written, one per cycle.
- PRE: count++ on each write. When P samples have been written, go to WAIT. The trigger is not evaluated in PRE.
- Per-bit match for masked bits:
  - Level bit (edge=0): trig_d==value.
  - Edge bit (edge=1): trig_d==value AND trig_q!=value AND edge history valid.
  - Edge history becomes valid after the first sample written following arm. An edge therefore cannot fire on the first captured sample.
- Trigger = AND over masked bits. Mask all zero means the trigger fires on the first WAIT cycle.
- WAIT: on a trigger cycle, the sample written that cycle is the trigger sample:
  - trig_pos_o<=wr_addr, triggered_o<=1, count<=0.
  - Go to POST, or straight to DONE if P==DEPTH-1.
- POST: write exactly DEPTH-P-1 further samples, then enter DONE. The last write leaves wr_addr == start address, where start = trig_pos-P mod DEPTH.
- DONE entry: done_o<=1, busy_o<=0, rd_ptr<=start, read count<=0. No writes occur in DONE.
- Readout:
  - rd_req_i in DONE issues a RAM read at rd_ptr, then rd_ptr++ (wrap).
  - rd_data_o and rd_valid_o follow 1 cycle after the request (synchronous RAM, latency 1).
  - Back-to-back requests give one sample per cycle.
  - rd_last_o accompanies the DEPTH-th valid.
  - Requests after DEPTH samples have been read, or outside DONE, are ignored with no rd_valid_o.
  - A re-arm or abort while a read is in flight suppresses that read's rd_valid_o.
- abort_i: from any state go to IDLE. Clear busy_o and done_o. triggered_o and trig_pos_o keep their values.
- Async reset mid-capture: returns to the reset state immediately; there is no partial-capture status.
- A trigger condition present in PRE is lost. The trigger is level/edge-sampled only in WAIT.

Test Plan:
1. DEPTH=16, P=4, mask=0001, value=0001, edge=0001, data_i=free-running counter, trig_i[0] rises at the sample whose data=20 -> 16 samples read back = 16..31, trig_pos_o=(20 mod 16)=4, rd_last_o with data 31.
2. Mask=0000, P=0 -> trigger on first WAIT sample, trig_pos_o=0, readout = first 16 samples after arm, done_o 17 cycles after arm (1 arm cycle + 16 writes).
3. Level trigger mask=0011, value=0010, trig_i held 2'b10 during PRE then kept -> fires on first WAIT cycle; same with edge=0011 -> does not fire until trig_i leaves and re-enters 10.
4. P=15 (DEPTH-1): trigger sample is the last entry, rd_last_o data equals trigger sample, no POST cycles.
5. abort_i asserted in POST together with arm_i -> state IDLE, done_o=0, no rd_valid_o on following rd_req_i; new arm restarts cleanly.
6. rst_n low during WAIT and during readout -> all outputs 0 asynchronously; 20 rd_req_i pulses after DONE -> exactly 16 rd_valid_o, rd_last_o only on the 16th.
